// File: rtl/alu_driver.sv
// rtl/alu_driver.sv - sequential command/response initiator for a combinational ALU
//
// Purpose:
//   Accepts one operation at a time on a valid/ready command channel and drives
//   registered operands and select onto an external combinational ALU. It holds
//   them for SETTLE cycles, captures alu_z, and returns the result on a
//   valid/ready response channel.
//
// Parameters:
//   W       operand width (result width is 2*W)
//   SETTLE  cycles operands are held before capture, 1..15
//
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; cmd_op/cmd_a/cmd_b payload
//   alu_x/alu_y/alu_s     registered operands and select driven to the ALU
//   alu_z                 ALU result input
//   rsp_valid/rsp_ready   response handshake; rsp_data payload
//   op_count              completed responses, wraps modulo 256
//   chk_err               sticky golden-model mismatch flag
//
// Optional feature macro: ALU_DRIVER_CHECK_EN (golden-model result check).
// When it is undefined, chk_err is tied to 0.

module alu_driver #(
  parameter int W      = 4,
  parameter int SETTLE = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [1:0]     cmd_op,
  input  logic [W-1:0]   cmd_a,
  input  logic [W-1:0]   cmd_b,
  output logic [W-1:0]   alu_x,
  output logic [W-1:0]   alu_y,
  output logic [1:0]     alu_s,
  input  logic [2*W-1:0] alu_z,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [2*W-1:0] rsp_data,
  output logic [7:0]     op_count,
  output logic           chk_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  localparam logic [1:0] OP_ZERO = 2'b11;

  logic [1:0]     state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [W-1:0]   x_q, x_d, y_q, y_d;
  logic [1:0]     s_q, s_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [2*W-1:0] rsp_data_q, rsp_data_d;
  logic [7:0]     op_count_q, op_count_d;
  logic           capture;

  // The capture edge is the last cycle of the settle window.
  assign capture = (state_q == DRIVE) && (cnt_q == 4'd0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    s_d         = s_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    op_count_d  = op_count_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = DRIVE;
          x_d     = cmd_a;
          y_d     = cmd_b;
          s_d     = cmd_op;
          cnt_d   = 4'(SETTLE - 1);
        end
      end
      DRIVE: begin
        if (capture) begin
          rsp_data_d  = alu_z;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        // Operands are left in place; only the select is parked on "zero".
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + 8'd1;
          s_d         = OP_ZERO;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      x_q         <= '0;
      y_q         <= '0;
      s_q         <= OP_ZERO;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      op_count_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      s_q         <= s_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      op_count_q  <= op_count_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign alu_x     = x_q;
  assign alu_y     = y_q;
  assign alu_s     = s_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign op_count  = op_count_q;

`ifdef ALU_DRIVER_CHECK_EN
  logic           chk_err_q, chk_err_d;
  logic [2*W-1:0] golden;

  // Expected result from the operands actually presented to the ALU.
  always_comb begin
    golden = '0;
    case (s_q)
      2'b00:   golden = {{W{1'b0}}, x_q} + {{W{1'b0}}, y_q};
      2'b01:   golden = {{W{1'b0}}, x_q} - {{W{1'b0}}, y_q};
      2'b10:   golden = {{W{1'b0}}, x_q} * {{W{1'b0}}, y_q};
      default: golden = '0;
    endcase
  end

  always_comb begin
    chk_err_d = chk_err_q;
    if (capture && (alu_z != golden)) chk_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) chk_err_q <= 1'b0;
    else     chk_err_q <= chk_err_d;
  end

  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_driver.sv
// tb/tb_alu_driver.sv - self-checking bench for alu_driver with randomized streams
module tb_alu_driver;

  localparam int W      = 4;
  localparam int SETTLE = 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [1:0]     cmd_op;
  logic [W-1:0]   cmd_a;
  logic [W-1:0]   cmd_b;
  logic [W-1:0]   alu_x;
  logic [W-1:0]   alu_y;
  logic [1:0]     alu_s;
  logic [2*W-1:0] alu_z;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [2*W-1:0] rsp_data;
  logic [7:0]     op_count;
  logic           chk_err;

  logic force_zero = 1'b0;
  int   n_checks   = 0;
  int   n_fail     = 0;
  int   exp_count  = 0;
  logic exp_chk;

  alu_driver #(.W(W), .SETTLE(SETTLE)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .alu_x     (alu_x),
    .alu_y     (alu_y),
    .alu_s     (alu_s),
    .alu_z     (alu_z),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .op_count  (op_count),
    .chk_err   (chk_err)
  );

  always #5 clk = ~clk;

  // Arithmetic reference: integer math truncated to the 8-bit result.
  function automatic logic [7:0] ref_alu(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    int r;
    case (op)
      2'b00:   r = int'(a) + int'(b);
      2'b01:   r = int'(a) - int'(b);
      2'b10:   r = int'(a) * int'(b);
      default: r = 0;
    endcase
    return r[7:0];
  endfunction

  // Behavioural ALU attached to the driver; force_zero injects a bad result.
  always_comb alu_z = force_zero ? 8'h00 : ref_alu(alu_s, alu_x, alu_y);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic do_op(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                       input int hold, input logic [7:0] exp_v);
    int n;
    @(negedge clk);
    check("idle_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    rsp_ready = (hold == 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("drive_x", alu_x, a);
    check("drive_y", alu_y, b);
    check("drive_s", alu_s, op);
    check("drive_no_rsp", rsp_valid, 0);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, SETTLE);
    check("rsp_data", rsp_data, exp_v);
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1;
      cmd_a     = ~a;
      @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_data", rsp_data, exp_v);
      check("hold_busy", cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    exp_count = (exp_count + 1) % 256;
    check("rsp_done", rsp_valid, 0);
    check("op_count", op_count, exp_count);
    check("idle_sel", alu_s, 2'b11);
    check("back_idle", cmd_ready, 1);
  endtask

  // Continuous random command stream; with rand_ready=0 the consumer never stalls,
  // so consecutive acceptances must be exactly SETTLE+2 cycles apart.
  task automatic run_stream(input int n_issue, input bit rand_ready);
    logic [7:0] exp_q[$];
    int         last_acc  = -1;
    bit         prev_hold = 1'b0;
    logic [7:0] prev_data = '0;
    cmd_op = 2'($urandom); cmd_a = 4'($urandom); cmd_b = 4'($urandom);
    for (int c = 0; c < n_issue + 60; c++) begin
      @(negedge clk);
      if (c >= n_issue && exp_q.size() == 0 && !rsp_valid) break;
      if (prev_hold) begin
        check("stall_valid", rsp_valid, 1);
        check("stall_data", rsp_data, prev_data);
      end
      check("stream_count", op_count, exp_count);
      rsp_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      cmd_valid = (c < n_issue);
      if (!cmd_ready) begin
        cmd_op = 2'($urandom); cmd_a = 4'($urandom); cmd_b = 4'($urandom);
      end
      if (cmd_valid && cmd_ready) begin
        if (!rand_ready && last_acc >= 0) check("issue_gap", c - last_acc, SETTLE + 2);
        last_acc = c;
        exp_q.push_back(ref_alu(cmd_op, cmd_a, cmd_b));
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
        else check("stream_data", rsp_data, exp_q.pop_front());
        exp_count = (exp_count + 1) % 256;
      end
      prev_hold = rsp_valid && !rsp_ready;
      prev_data = rsp_data;
    end
    check("stream_drained", exp_q.size(), 0);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
  endtask

  initial begin
`ifdef ALU_DRIVER_CHECK_EN
    exp_chk = 1'b1;
`else
    exp_chk = 1'b0;
`endif
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_sel", alu_s, 2'b11);
    check("rst_x", alu_x, 0);
    check("rst_count", op_count, 0);
    check("rst_chk", chk_err, 0);
    rst = 1'b0;

    do_op(2'b00, 4'd4, 4'd5, 0, 8'd9);
    do_op(2'b01, 4'd10, 4'd2, 0, 8'd8);
    do_op(2'b01, 4'd3, 4'd5, 0, 8'hFE);
    do_op(2'b10, 4'd4, 4'd7, 5, 8'd28);
    do_op(2'b11, 4'd4, 4'd7, 0, 8'd0);
    do_op(2'b10, 4'd15, 4'd15, 0, 8'd225);
    do_op(2'b01, 4'd0, 4'd15, 0, 8'hF1);

    // Reset while the command sits in DRIVE: nothing may come out.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 4'd3; cmd_b = 4'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_count = 0;
    check("mid_rst_rsp", rsp_valid, 0);
    check("mid_rst_sel", alu_s, 2'b11);
    check("mid_rst_count", op_count, 0);
    check("mid_rst_ready", cmd_ready, 1);
    repeat (3) begin
      @(negedge clk);
      check("mid_rst_quiet", rsp_valid, 0);
    end

    run_stream(800, 1'b0);
    run_stream(400, 1'b1);

    force_zero = 1'b1;
    do_op(2'b00, 4'd1, 4'd1, 0, 8'd0);
    force_zero = 1'b0;
    check("chk_set", chk_err, exp_chk);
    do_op(2'b00, 4'd2, 4'd3, 0, 8'd5);
    do_op(2'b10, 4'd3, 4'd3, 0, 8'd9);
    check("chk_sticky", chk_err, exp_chk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_count = 0;
    check("chk_cleared", chk_err, 0);
    check("final_count", op_count, exp_count);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
